// File: rtl/trace_checker.sv
// Compares a core's retired-instruction trace against a table of
// (instruction count, expected output) checkpoints and reports a verdict.
module trace_checker #(
    parameter int DWIDTH  = 32,
    parameter int NCHK    = 32,
    parameter int AWIDTH  = 5,
    parameter int TIMEOUT = 1000000
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CFG_WE,
    input  logic [AWIDTH-1:0] CFG_ADDR,
    input  logic [DWIDTH-1:0] CFG_INST,
    input  logic [DWIDTH-1:0] CFG_ANS,
    input  logic [AWIDTH:0]   CFG_NUM,
    input  logic              START,
    input  logic              STOP_ON_FAIL,
    input  logic [DWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic [2:0]        STATE,
    output logic              PASS,
    output logic [AWIDTH-1:0] FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_GOT,
    output logic              MISS,
    output logic [AWIDTH:0]   PASS_CNT,
    output logic [AWIDTH:0]   FAIL_CNT,
    output logic [31:0]       CYCLE
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DONE  = 3'd2,
        S_ABORT = 3'd3,
        S_TOUT  = 3'd4
    } state_t;

    localparam logic [31:0]   TO_LIM = 32'(TIMEOUT - 1);
    localparam logic [AWIDTH:0] NCHK_W = (AWIDTH + 1)'(NCHK);

    // Checkpoint table survives reset so a rerun needs no reload.
    logic [DWIDTH-1:0] inst_tbl [NCHK];
    logic [DWIDTH-1:0] ans_tbl  [NCHK];

    state_t            state_q, state_d;
    logic [AWIDTH:0]   ptr_q, ptr_d, num_q, num_d;
    logic [AWIDTH:0]   pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic              sof_q, sof_d, pass_q, pass_d, miss_q, miss_d;
    logic [AWIDTH-1:0] fail_idx_q, fail_idx_d;
    logic [DWIDTH-1:0] fail_got_q, fail_got_d;
    logic [31:0]       cycle_q, cycle_d;

    logic              ev_valid, ev_hit, ev_miss, ev_fail;
    logic [AWIDTH:0]   ptr_n, rem;
    logic [DWIDTH-1:0] cur_inst, cur_ans;

    always_ff @(posedge CLK) begin
        if (CFG_WE && state_q != S_RUN) begin
            inst_tbl[CFG_ADDR] <= CFG_INST;
            ans_tbl[CFG_ADDR]  <= CFG_ANS;
        end
    end

    assign cur_inst = inst_tbl[ptr_q[AWIDTH-1:0]];
    assign cur_ans  = ans_tbl[ptr_q[AWIDTH-1:0]];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        num_d      = num_q;
        sof_d      = sof_q;
        pass_d     = pass_q;
        miss_d     = miss_q;
        fail_idx_d = fail_idx_q;
        fail_got_d = fail_got_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        cycle_d    = cycle_q;
        ev_valid   = ptr_q < num_q;
        ev_hit     = ev_valid && (NUM_INST == cur_inst);
        ev_miss    = ev_valid && (NUM_INST > cur_inst);
        ev_fail    = ev_miss || (ev_hit && OUTPUT_PORT != cur_ans);
        ptr_n      = ptr_q;
        rem        = '0;

        case (state_q)
            S_RUN: begin
                if (cycle_q != 32'hFFFF_FFFF)
                    cycle_d = cycle_q + 32'd1;
                if (ev_hit || ev_miss)
                    ptr_n = ptr_q + 1'b1;
                if (ev_hit && !ev_fail)
                    pass_cnt_d = pass_cnt_q + 1'b1;
                if (ev_fail) begin
                    fail_cnt_d = fail_cnt_q + 1'b1;
                    if (fail_cnt_q == '0) begin
                        fail_idx_d = ptr_q[AWIDTH-1:0];
                        fail_got_d = OUTPUT_PORT;
                        miss_d     = ev_miss;
                    end
                end
                ptr_d = ptr_n;

                if (ev_fail && sof_q) begin
                    state_d = S_ABORT;
                end else if (HALT) begin
                    // Entries never reached before halt count as missed.
                    rem = num_q - ptr_n;
                    if (rem != '0) begin
                        fail_cnt_d = fail_cnt_d + rem;
                        ptr_d      = num_q;
                        if (fail_cnt_q == '0 && !ev_fail) begin
                            fail_idx_d = ptr_n[AWIDTH-1:0];
                            fail_got_d = OUTPUT_PORT;
                            miss_d     = 1'b1;
                        end
                    end
                    pass_d  = (fail_cnt_d == '0);
                    state_d = S_DONE;
                end else if (cycle_d >= TO_LIM) begin
                    state_d = S_TOUT;
                end
            end
            default: begin
                if (START) begin
                    state_d    = S_RUN;
                    ptr_d      = '0;
                    num_d      = (CFG_NUM > NCHK_W) ? NCHK_W : CFG_NUM;
                    sof_d      = STOP_ON_FAIL;
                    pass_d     = 1'b0;
                    miss_d     = 1'b0;
                    fail_idx_d = '0;
                    fail_got_d = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    cycle_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            num_q      <= '0;
            sof_q      <= 1'b0;
            pass_q     <= 1'b0;
            miss_q     <= 1'b0;
            fail_idx_q <= '0;
            fail_got_q <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            cycle_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            num_q      <= num_d;
            sof_q      <= sof_d;
            pass_q     <= pass_d;
            miss_q     <= miss_d;
            fail_idx_q <= fail_idx_d;
            fail_got_q <= fail_got_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            cycle_q    <= cycle_d;
        end
    end

    assign STATE    = state_q;
    assign PASS     = pass_q;
    assign FAIL_IDX = fail_idx_q;
    assign FAIL_GOT = fail_got_q;
    assign MISS     = miss_q;
    assign PASS_CNT = pass_cnt_q;
    assign FAIL_CNT = fail_cnt_q;
    assign CYCLE    = cycle_q;
endmodule

// File: tb/tb_trace_checker.sv
// Scoreboard bench for trace_checker: expected verdicts are queued when a
// scenario is armed and compared when the checker reaches a terminal state.
module tb_trace_checker;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        CFG_WE = 1'b0;
    logic [2:0]  CFG_ADDR = '0;
    logic [31:0] CFG_INST = '0, CFG_ANS = '0;
    logic [3:0]  CFG_NUM = '0;
    logic        START = 1'b0, STOP_ON_FAIL = 1'b0, HALT = 1'b0;
    logic [31:0] NUM_INST = '0, OUTPUT_PORT = '0;
    logic [2:0]  STATE;
    logic        PASS, MISS;
    logic [2:0]  FAIL_IDX;
    logic [31:0] FAIL_GOT, CYCLE;
    logic [3:0]  PASS_CNT, FAIL_CNT;

    typedef struct packed {
        logic [2:0]  st;
        logic        pass;
        logic [3:0]  pc;
        logic [3:0]  fc;
        logic [2:0]  fi;
        logic [31:0] fg;
        logic        miss;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0;

    trace_checker #(.DWIDTH(32), .NCHK(8), .AWIDTH(3), .TIMEOUT(20)) dut (
        .CLK(CLK), .RSTn(RSTn), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
        .CFG_INST(CFG_INST), .CFG_ANS(CFG_ANS), .CFG_NUM(CFG_NUM),
        .START(START), .STOP_ON_FAIL(STOP_ON_FAIL), .NUM_INST(NUM_INST),
        .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .STATE(STATE), .PASS(PASS),
        .FAIL_IDX(FAIL_IDX), .FAIL_GOT(FAIL_GOT), .MISS(MISS),
        .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT), .CYCLE(CYCLE)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t obs();
        return '{st: STATE, pass: PASS, pc: PASS_CNT, fc: FAIL_CNT,
                 fi: FAIL_IDX, fg: FAIL_GOT, miss: MISS};
    endfunction

    function automatic exp_t mk(input logic [2:0] st, input logic p,
                                input logic [3:0] pc, input logic [3:0] fc,
                                input logic [2:0] fi, input logic [31:0] fg,
                                input logic m);
        return '{st: st, pass: p, pc: pc, fc: fc, fi: fi, fg: fg, miss: m};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] i, input logic [31:0] v);
        CFG_WE = 1'b1; CFG_ADDR = a; CFG_INST = i; CFG_ANS = v;
        step();
        CFG_WE = 1'b0;
    endtask

    task automatic arm(input logic [3:0] num, input logic sof);
        NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
        CFG_NUM = num; STOP_ON_FAIL = sof; START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic drive(input logic [31:0] ni, input logic [31:0] op);
        NUM_INST = ni; OUTPUT_PORT = op;
        step();
    endtask

    task automatic halt_now();
        HALT = 1'b1;
        step();
        HALT = 1'b0;
    endtask

    task automatic wait_term(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (STATE >= 3'd2) begin ok = 1'b1; break; end
            step();
        end
        if (STATE >= 3'd2) ok = 1'b1;
    endtask

    task automatic test_reset();
        exp_t o;
        RSTn = 1'b0;
        step(); step();
        RSTn = 1'b1;
        o = obs();
        n_tests++;
        if (o !== '0 || CYCLE !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: got %h cycle %0d, expected all zero", o, CYCLE);
        end
    endtask

    task automatic test_main();
        exp_t e, o;
        bit ok;
        cfg_write(3'd0, 32'd4, 32'hEEC);
        cfg_write(3'd1, 32'd6, 32'd0);
        cfg_write(3'd2, 32'd8, 32'd1);
        sb.push_back(mk(3'd2, 1'b1, 4'd3, 4'd0, 3'd0, 32'd0, 1'b0));
        arm(4'd3, 1'b0);
        n_tests++;
        if (STATE !== 3'd1) begin
            n_fail++;
            $display("FAIL main_run_state: got %0d expected 1", STATE);
        end
        drive(32'd4, 32'hEEC);
        drive(32'd6, 32'd0);
        drive(32'd8, 32'd1);
        halt_now();
        wait_term(5, ok);
        e = sb.pop_front();
        o = obs();
        n_tests++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL main_verdict: got %h expected %h", o, e);
        end
        n_tests++;
        if (CYCLE !== 32'd4) begin
            n_fail++;
            $display("FAIL main_cycle: got %0d expected 4", CYCLE);
        end
        // Terminal state must hold through input activity.
        drive(32'd100, 32'h55);
        HALT = 1'b1; step(); HALT = 1'b0;
        cfg_write(3'd7, 32'd3, 32'd3);
        o = obs();
        n_tests++;
        if (o !== e || CYCLE !== 32'd4) begin
            n_fail++;
            $display("FAIL main_hold: got %h cycle %0d expected %h cycle 4", o, CYCLE, e);
        end
    endtask

    task automatic test_abort();
        exp_t e, o;
        bit ok;
        sb.push_back(mk(3'd3, 1'b0, 4'd1, 4'd1, 3'd1, 32'h5, 1'b0));
        arm(4'd3, 1'b1);
        drive(32'd4, 32'hEEC);
        drive(32'd6, 32'h5);
        wait_term(5, ok);
        e = sb.pop_front();
        o = obs();
        n_tests++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL abort: got %h expected %h", o, e);
        end
    endtask

    task automatic test_miss();
        exp_t e, o;
        bit ok;
        sb.push_back(mk(3'd2, 1'b0, 4'd2, 4'd1, 3'd1, 32'h77, 1'b1));
        arm(4'd3, 1'b0);
        drive(32'd4, 32'hEEC);
        drive(32'd7, 32'h77);
        n_tests++;
        if (MISS !== 1'b1 || FAIL_IDX !== 3'd1 || STATE !== 3'd1) begin
            n_fail++;
            $display("FAIL miss_flag: got miss %b idx %0d st %0d expected 1 1 1", MISS, FAIL_IDX, STATE);
        end
        drive(32'd8, 32'd1);
        halt_now();
        wait_term(5, ok);
        e = sb.pop_front();
        o = obs();
        n_tests++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL miss_verdict: got %h expected %h", o, e);
        end
    endtask

    task automatic test_timeout();
        exp_t e, o;
        bit ok, seen;
        sb.push_back(mk(3'd4, 1'b0, 4'd0, 4'd0, 3'd0, 32'd0, 1'b0));
        arm(4'd3, 1'b0);
        wait_term(40, ok);
        e = sb.pop_front();
        o = obs();
        n_tests++;
        if (!ok || o !== e || CYCLE !== 32'd19) begin
            n_fail++;
            $display("FAIL timeout: got %h cycle %0d expected %h cycle 19", o, CYCLE, e);
        end
        // Empty table with HALT exactly on the timeout edge: DONE wins.
        sb.push_back(mk(3'd2, 1'b1, 4'd0, 4'd0, 3'd0, 32'd0, 1'b0));
        arm(4'd0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (CYCLE == 32'd18 && STATE == 3'd1) begin seen = 1'b1; break; end
            step();
        end
        HALT = 1'b1; step(); HALT = 1'b0;
        e = sb.pop_front();
        o = obs();
        n_tests++;
        if (!seen || o !== e || CYCLE !== 32'd19) begin
            n_fail++;
            $display("FAIL timeout_halt: got %h cycle %0d seen %b expected %h cycle 19", o, CYCLE, seen, e);
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e, o;
        bit ok;
        arm(4'd3, 1'b1);
        drive(32'd4, 32'hEEC);
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        o = obs();
        n_tests++;
        if (o !== '0 || CYCLE !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_midrun: got %h cycle %0d expected all zero", o, CYCLE);
        end
        sb.push_back(mk(3'd2, 1'b1, 4'd3, 4'd0, 3'd0, 32'd0, 1'b0));
        arm(4'd3, 1'b0);
        drive(32'd4, 32'hEEC);
        drive(32'd6, 32'd0);
        drive(32'd8, 32'd1);
        halt_now();
        wait_term(5, ok);
        e = sb.pop_front();
        o = obs();
        n_tests++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL rerun: got %h expected %h", o, e);
        end
    endtask

    task automatic test_cfg_in_run();
        exp_t e, o;
        bit ok;
        sb.push_back(mk(3'd2, 1'b1, 4'd3, 4'd0, 3'd0, 32'd0, 1'b0));
        arm(4'd3, 1'b0);
        drive(32'd4, 32'hEEC);
        cfg_write(3'd2, 32'd8, 32'h99);
        START = 1'b1; step(); START = 1'b0;
        n_tests++;
        if (PASS_CNT !== 4'd1 || STATE !== 3'd1) begin
            n_fail++;
            $display("FAIL start_in_run: got pc %0d st %0d expected 1 1", PASS_CNT, STATE);
        end
        drive(32'd6, 32'd0);
        drive(32'd8, 32'd1);
        halt_now();
        wait_term(5, ok);
        e = sb.pop_front();
        o = obs();
        n_tests++;
        if (!ok || o !== e) begin
            n_fail++;
            $display("FAIL cfg_in_run: got %h expected %h", o, e);
        end
    endtask

    task automatic test_num_sat();
        exp_t e, o;
        sb.push_back(mk(3'd2, 1'b0, 4'd0, 4'd8, 3'd0, 32'd0, 1'b1));
        arm(4'd15, 1'b0);
        halt_now();
        e = sb.pop_front();
        o = obs();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL num_sat: got %h expected %h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_main();
        test_abort();
        test_miss();
        test_timeout();
        test_reset_midrun();
        test_cfg_in_run();
        test_num_sat();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameter DWIDTH, default 32, width of instruction-count and data compare values.
REQ-002 Parameter NCHK, default 32, checkpoint table depth.
REQ-003 Parameter AWIDTH, default 5, table index width; NCHK SHALL equal 2**AWIDTH.
REQ-004 Parameter TIMEOUT, default 1000000, run-cycle limit before abort.
REQ-005 Reset is RSTn, synchronous, active-low; clock is CLK.
REQ-006 CLK  in  1  clock.
REQ-007 RSTn  in  1  synchronous active-low reset.
REQ-008 CFG_WE  in  1  table write strobe.
REQ-009 CFG_ADDR  in  AWIDTH  table write index.
REQ-010 CFG_INST  in  DWIDTH  checkpoint instruction count.
REQ-011 CFG_ANS  in  DWIDTH  expected OUTPUT_PORT value.
REQ-012 CFG_NUM  in  AWIDTH+1  number of valid entries, sampled on START.
REQ-013 START  in  1  arm/rearm pulse.
REQ-014 STOP_ON_FAIL  in  1  mode, sampled on START: 1 = abort on first failure.
REQ-015 NUM_INST, OUTPUT_PORT  in  DWIDTH each  core retired-instruction count and observed output.
REQ-016 HALT  in  1  core halt indication.
REQ-017 STATE  out  3  FSM state code.
REQ-018 PASS  out  1  final verdict; FAIL_IDX  out  AWIDTH  first failing entry; FAIL_GOT  out  DWIDTH  value seen at first failure; MISS  out  1  first failure was a skipped checkpoint.
REQ-019 PASS_CNT, FAIL_CNT  out  AWIDTH+1 each; CYCLE  out  32  cycles spent in RUN.

Function
REQ-020 Table writes SHALL take effect on the CLK edge with CFG_WE=1, only in IDLE or a terminal state; writes in RUN SHALL be ignored.
REQ-021 States SHALL be IDLE=0, RUN=1, DONE=2, ABORT=3, TOUT=4; codes 5-7 unreachable.
REQ-022 START in IDLE or any terminal state -> RUN next cycle; ptr, PASS_CNT, FAIL_CNT, CYCLE, FAIL_IDX, FAIL_GOT, MISS, PASS cleared; CFG_NUM latched, saturated to NCHK.
REQ-023 START while in RUN SHALL be ignored.
REQ-024 In RUN, CYCLE SHALL increment by 1 per cycle, saturating at 2**32-1.
REQ-025 In RUN with ptr < num: NUM_INST == inst[ptr] -> compare OUTPUT_PORT to ans[ptr]; match -> PASS_CNT+1; mismatch -> FAIL_CNT+1; ptr+1 either way.
REQ-026 In RUN with ptr < num and NUM_INST > inst[ptr] (unsigned) -> missed checkpoint: FAIL_CNT+1, ptr+1, MISS set if first failure.
REQ-027 At most one entry SHALL be evaluated per cycle; entries are required strictly increasing in inst.
REQ-028 First failure SHALL capture FAIL_IDX=ptr and FAIL_GOT=OUTPUT_PORT; later failures SHALL NOT overwrite them.
REQ-029 Failure with latched STOP_ON_FAIL=1 -> ABORT next cycle, PASS=0.
REQ-030 HALT=1 in RUN -> same-cycle checkpoint evaluation first; then remaining entries (ptr..num-1) added to FAIL_CNT as missed; -> DONE with PASS = (final FAIL_CNT == 0).
REQ-031 HALT and failure with STOP_ON_FAIL=1 in the same cycle -> ABORT takes priority.
REQ-032 CYCLE reaching TIMEOUT-1 in RUN without HALT -> TOUT, PASS=0; HALT in that same cycle -> DONE takes priority.
REQ-033 latched num=0 -> no checks; HALT -> DONE with PASS=1.
REQ-034 Terminal states SHALL hold all outputs stable until START or reset.
REQ-035 Outputs SHALL be registered; verdict visible one cycle after the triggering edge.

Reset
REQ-036 RSTn=0 at a CLK edge -> STATE=IDLE, all outputs 0, ptr=0, latched num=0, STOP_ON_FAIL latch=0, also mid-RUN.
REQ-037 Table contents SHALL NOT be cleared by reset.

Verification
REQ-038 3 entries (4,0xEEC),(6,0),(8,1); NUM_INST 4,6,8 with matching OUTPUT_PORT, then HALT -> DONE, PASS=1, PASS_CNT=3, FAIL_CNT=0.
REQ-039 Same table, STOP_ON_FAIL=1, OUTPUT_PORT=0x5 at NUM_INST=6 -> ABORT, FAIL_IDX=1, FAIL_GOT=0x5, MISS=0, PASS_CNT=1.
REQ-040 Same table, STOP_ON_FAIL=0, NUM_INST jumps 4->7 -> entry 1 missed, MISS=1, FAIL_IDX=1; HALT after 8 -> DONE, PASS=0, FAIL_CNT=1, PASS_CNT=2.
REQ-041 TIMEOUT=20, no HALT -> TOUT entered after CYCLE=19, PASS=0; HALT at that same cycle -> DONE instead.
REQ-042 RSTn=0 mid-RUN, after 1 entry passed -> IDLE, all outputs 0; table kept; START -> rerun passes.
REQ-043 CFG_WE during RUN modifying entry 2 -> ignored; entry 2 still checked against original value.
